ex_operand_stage: RTL and testbench

EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

---
 rtl/ex_operand_stage.sv | 117 +++++++++++
 tb/tb_ex_operand_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// ID/EX stage register with operand forwarding, load-use stall detection and a
// saturating stall-cycle counter.
module ex_operand_stage #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic [31:0]      id_rs_data,
  input  logic [31:0]      id_rt_data,
  input  logic [31:0]      id_imm,
  input  logic             id_alusrc,
  input  logic [3:0]       id_aluctl,
  input  logic             id_memread,
  input  logic             id_regwrite,
  input  logic             exmem_regwrite,
  input  logic [4:0]       exmem_rd,
  input  logic [31:0]      exmem_data,
  input  logic             memwb_regwrite,
  input  logic [4:0]       memwb_rd,
  input  logic [31:0]      memwb_data,
  output logic             ex_valid,
  output logic             ex_memread,
  output logic             ex_regwrite,
  output logic [3:0]       ex_ctl,
  output logic [4:0]       ex_rd,
  output logic [31:0]      ex_a,
  output logic [31:0]      ex_b,
  output logic [31:0]      ex_store_data,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);

  logic             valid_q, memread_q, regwrite_q, alusrc_q;
  logic [4:0]       rs_q, rt_q, rd_q;
  logic [3:0]       aluctl_q;
  logic [31:0]      rs_data_q, rt_data_q, imm_q;
  logic [CNT_W-1:0] count_q;
  logic             bubble;
  logic [31:0]      rs_fwd, rt_fwd;

  assign stall = valid_q & memread_q & regwrite_q & (rd_q != 5'd0) & id_valid & ~flush &
                 ((id_rs == rd_q) | (id_rt == rd_q));

  assign bubble = reset | flush | stall;

  always_ff @(posedge clk) begin
    if (bubble) begin
      valid_q    <= 1'b0;
      memread_q  <= 1'b0;
      regwrite_q <= 1'b0;
      aluctl_q   <= 4'b0000;
      rd_q       <= 5'd0;
      rs_q       <= 5'd0;
      rt_q       <= 5'd0;
      alusrc_q   <= 1'b0;
    end else begin
      valid_q    <= id_valid;
      memread_q  <= id_memread;
      regwrite_q <= id_regwrite;
      aluctl_q   <= id_aluctl;
      rd_q       <= id_rd;
      rs_q       <= id_rs;
      rt_q       <= id_rt;
      alusrc_q   <= id_alusrc;
    end
  end

  // Data fields are don't-care in a bubble, so they load unconditionally.
  always_ff @(posedge clk) begin
    rs_data_q <= id_rs_data;
    rt_data_q <= id_rt_data;
    imm_q     <= id_imm;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (stall && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // EX/MEM wins over MEM/WB; register 0 always keeps its registered value.
  always_comb begin
    rs_fwd = rs_data_q;
    if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == rs_q)) begin
      rs_fwd = exmem_data;
    end else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == rs_q)) begin
      rs_fwd = memwb_data;
    end
  end

  always_comb begin
    rt_fwd = rt_data_q;
    if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == rt_q)) begin
      rt_fwd = exmem_data;
    end else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == rt_q)) begin
      rt_fwd = memwb_data;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_memread    = memread_q;
  assign ex_regwrite   = regwrite_q;
  assign ex_ctl        = aluctl_q;
  assign ex_rd         = rd_q;
  assign ex_a          = rs_fwd;
  assign ex_b          = alusrc_q ? imm_q : rt_fwd;
  assign ex_store_data = rt_fwd;
  assign stall_count   = count_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: a default-width instance and a CNT_W=2
// instance share all stimulus so counter saturation can be observed.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset, flush, id_valid, id_alusrc, id_memread, id_regwrite;
  logic [4:0]  id_rs, id_rt, id_rd, exmem_rd, memwb_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm, exmem_data, memwb_data;
  logic [3:0]  id_aluctl;
  logic        exmem_regwrite, memwb_regwrite;

  logic        ex_valid, ex_memread, ex_regwrite, stall;
  logic [3:0]  ex_ctl;
  logic [4:0]  ex_rd;
  logic [31:0] ex_a, ex_b, ex_store_data;
  logic [15:0] stall_count;

  logic        s_valid, s_memread, s_regwrite, s_stall;
  logic [3:0]  s_ctl;
  logic [4:0]  s_rd;
  logic [31:0] s_a, s_b, s_store;
  logic [1:0]  s_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alusrc(id_alusrc), .id_aluctl(id_aluctl),
    .id_memread(id_memread), .id_regwrite(id_regwrite),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
    .ex_ctl(ex_ctl), .ex_rd(ex_rd), .ex_a(ex_a), .ex_b(ex_b),
    .ex_store_data(ex_store_data), .stall(stall), .stall_count(stall_count)
  );

  ex_operand_stage #(.CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alusrc(id_alusrc), .id_aluctl(id_aluctl),
    .id_memread(id_memread), .id_regwrite(id_regwrite),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .ex_valid(s_valid), .ex_memread(s_memread), .ex_regwrite(s_regwrite),
    .ex_ctl(s_ctl), .ex_rd(s_rd), .ex_a(s_a), .ex_b(s_b),
    .ex_store_data(s_store), .stall(s_stall), .stall_count(s_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                        input logic alusrc, input logic memread);
    id_valid = 1'b1; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    id_alusrc = alusrc; id_aluctl = 4'b0010; id_memread = memread; id_regwrite = 1'b1;
  endtask

  task automatic clear_fwd();
    exmem_regwrite = 1'b0; exmem_rd = 5'd0; exmem_data = 32'h0;
    memwb_regwrite = 1'b0; memwb_rd = 5'd0; memwb_data = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; clear_fwd();
    set_id(5'd3, 5'd4, 5'd5, 32'h1, 32'h2, 32'h3, 1'b0, 1'b1);
    tick(); tick();
    reset = 1'b0; id_valid = 1'b0;
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", ex_valid); end
    n_checks++; if (ex_memread !== 1'b0) begin n_fail++; $display("FAIL reset_memread got %b want 0", ex_memread); end
    n_checks++; if (ex_regwrite !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite got %b want 0", ex_regwrite); end
    n_checks++; if (ex_ctl !== 4'd0) begin n_fail++; $display("FAIL reset_ctl got %h want 0", ex_ctl); end
    n_checks++; if (ex_rd !== 5'd0) begin n_fail++; $display("FAIL reset_rd got %0d want 0", ex_rd); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall); end
    n_checks++; if (stall_count !== 16'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", stall_count); end
    n_checks++; if (s_count !== 2'd0) begin n_fail++; $display("FAIL reset_count_small got %0d want 0", s_count); end
  endtask

  task automatic test_forward_priority();
    set_id(5'd5, 5'd6, 5'd9, 32'hAAAA0000, 32'h0000BBBB, 32'h0, 1'b0, 1'b0);
    tick();
    exmem_regwrite = 1'b1; exmem_rd = 5'd5; exmem_data = 32'h11111111;
    memwb_regwrite = 1'b1; memwb_rd = 5'd5; memwb_data = 32'h22222222;
    #1;
    n_checks++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL fwd_valid got %b want 1", ex_valid); end
    n_checks++; if (ex_rd !== 5'd9) begin n_fail++; $display("FAIL fwd_rd got %0d want 9", ex_rd); end
    n_checks++; if (ex_ctl !== 4'b0010) begin n_fail++; $display("FAIL fwd_ctl got %h want 2", ex_ctl); end
    n_checks++; if (ex_a !== 32'h11111111) begin n_fail++; $display("FAIL fwd_exmem got %h want 11111111", ex_a); end
    n_checks++; if (ex_b !== 32'h0000BBBB) begin n_fail++; $display("FAIL fwd_b_regfile got %h want 0000bbbb", ex_b); end
    exmem_regwrite = 1'b0; #1;
    n_checks++; if (ex_a !== 32'h22222222) begin n_fail++; $display("FAIL fwd_memwb got %h want 22222222", ex_a); end
    memwb_regwrite = 1'b0; #1;
    n_checks++; if (ex_a !== 32'hAAAA0000) begin n_fail++; $display("FAIL fwd_none got %h want aaaa0000", ex_a); end
    memwb_regwrite = 1'b1; memwb_rd = 5'd6; memwb_data = 32'h33; #1;
    n_checks++; if (ex_b !== 32'h33) begin n_fail++; $display("FAIL fwd_rt_b got %h want 33", ex_b); end
    n_checks++; if (ex_store_data !== 32'h33) begin n_fail++; $display("FAIL fwd_rt_store got %h want 33", ex_store_data); end
    clear_fwd();
  endtask

  task automatic test_zero_reg();
    set_id(5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    exmem_regwrite = 1'b1; exmem_rd = 5'd0; exmem_data = 32'hDEADBEEF;
    memwb_regwrite = 1'b1; memwb_rd = 5'd0; memwb_data = 32'hCAFEF00D;
    #1;
    n_checks++; if (ex_a !== 32'h0) begin n_fail++; $display("FAIL zero_a got %h want 0", ex_a); end
    n_checks++; if (ex_b !== 32'h0) begin n_fail++; $display("FAIL zero_b got %h want 0", ex_b); end
    clear_fwd();
  endtask

  task automatic test_imm_select();
    set_id(5'd1, 5'd7, 5'd2, 32'h0, 32'h100, 32'hFFFFFFFC, 1'b1, 1'b0);
    tick();
    exmem_regwrite = 1'b1; exmem_rd = 5'd7; exmem_data = 32'h7;
    #1;
    n_checks++; if (ex_b !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL imm_b got %h want fffffffc", ex_b); end
    n_checks++; if (ex_store_data !== 32'h7) begin n_fail++; $display("FAIL imm_store got %h want 7", ex_store_data); end
    clear_fwd();
  endtask

  task automatic test_load_use();
    set_id(5'd1, 5'd2, 5'd8, 32'h0, 32'h0, 32'h4, 1'b1, 1'b1);
    tick();
    set_id(5'd8, 5'd3, 5'd10, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall got %b want 1", stall); end
    tick();
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble_valid got %b want 0", ex_valid); end
    n_checks++; if (ex_rd !== 5'd0) begin n_fail++; $display("FAIL lu_bubble_rd got %0d want 0", ex_rd); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_drop got %b want 0", stall); end
    n_checks++; if (stall_count !== 16'd1) begin n_fail++; $display("FAIL lu_count got %0d want 1", stall_count); end
    tick();
    n_checks++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL lu_dep_valid got %b want 1", ex_valid); end
    n_checks++; if (ex_rd !== 5'd10) begin n_fail++; $display("FAIL lu_dep_rd got %0d want 10", ex_rd); end
    n_checks++; if (stall_count !== 16'd1) begin n_fail++; $display("FAIL lu_count_hold got %0d want 1", stall_count); end
  endtask

  task automatic test_flush_vs_stall();
    set_id(5'd1, 5'd2, 5'd8, 32'h0, 32'h0, 32'h4, 1'b1, 1'b1);
    tick();
    set_id(5'd8, 5'd3, 5'd10, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    flush = 1'b1; #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL fl_stall got %b want 0", stall); end
    tick();
    flush = 1'b0;
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL fl_bubble got %b want 0", ex_valid); end
    n_checks++; if (ex_regwrite !== 1'b0) begin n_fail++; $display("FAIL fl_regwrite got %b want 0", ex_regwrite); end
    n_checks++; if (stall_count !== 16'd1) begin n_fail++; $display("FAIL fl_count got %0d want 1", stall_count); end
  endtask

  task automatic test_back_to_back_saturation();
    for (int i = 0; i < 5; i++) begin
      set_id(5'd1, 5'd2, 5'd8, 32'h0, 32'h0, 32'h4, 1'b1, 1'b1);
      tick();
      set_id(5'd4, 5'd8, 5'd10, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      #1;
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL b2b_stall_%0d got %b want 1", i, stall); end
      tick();
    end
    n_checks++; if (stall_count !== 16'd6) begin n_fail++; $display("FAIL b2b_count got %0d want 6", stall_count); end
    n_checks++; if (s_count !== 2'd3) begin n_fail++; $display("FAIL sat_count got %0d want 3", s_count); end
    set_id(5'd1, 5'd2, 5'd8, 32'h0, 32'h0, 32'h4, 1'b1, 1'b1);
    tick();
    set_id(5'd8, 5'd3, 5'd10, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    reset = 1'b1; #1;
    n_checks++; if (s_stall !== 1'b1) begin n_fail++; $display("FAIL rst_pre_stall got %b want 1", s_stall); end
    tick();
    reset = 1'b0; #1;
    n_checks++; if (s_count !== 2'd0) begin n_fail++; $display("FAIL rst_count_small got %0d want 0", s_count); end
    n_checks++; if (stall_count !== 16'd0) begin n_fail++; $display("FAIL rst_count got %0d want 0", stall_count); end
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", ex_valid); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %b want 0", stall); end
  endtask

  initial begin
    test_reset();
    test_forward_priority();
    test_zero_reg();
    test_imm_select();
    test_load_use();
    test_flush_vs_stall();
    test_back_to_back_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
